// File: rtl/buzzer_arbiter_pkg.sv
// Shared definitions for the buzzer arbiter: grant encodings, silence code,
// note frequencies and the arbitration state type.
package buzzer_arbiter_pkg;

  localparam int unsigned HZ_W = 12;

  localparam logic [1:0] GNT_NONE  = 2'd0;
  localparam logic [1:0] GNT_MUSIC = 2'd1;
  localparam logic [1:0] GNT_BEEP  = 2'd2;
  localparam logic [1:0] GNT_ALARM = 2'd3;

  localparam logic [HZ_W-1:0] NO_VOICE = 12'd0;

  localparam logic [HZ_W-1:0] NOTE_C4 = 12'd262;
  localparam logic [HZ_W-1:0] NOTE_E4 = 12'd330;
  localparam logic [HZ_W-1:0] NOTE_G4 = 12'd392;
  localparam logic [HZ_W-1:0] NOTE_A4 = 12'd440;
  localparam logic [HZ_W-1:0] NOTE_C5 = 12'd523;
  localparam logic [HZ_W-1:0] NOTE_A5 = 12'd880;
  localparam logic [HZ_W-1:0] NOTE_B5 = 12'd988;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUSIC,
    ST_BEEP,
    ST_ALARM
  } arb_state_t;

  function automatic logic [1:0] grant_of(arb_state_t s);
    case (s)
      ST_MUSIC: return GNT_MUSIC;
      ST_BEEP:  return GNT_BEEP;
      ST_ALARM: return GNT_ALARM;
      default:  return GNT_NONE;
    endcase
  endfunction

endpackage

// File: rtl/buzzer_arbiter_tick.sv
// Free-running millisecond tick: one-cycle pulse every CLK_PER_MS clocks.
module ms_tick_gen #(
  parameter int unsigned CLK_PER_MS = 100_000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned CNT_W = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_PER_MS - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)                 cnt <= '0;
    else if (cnt == CNT_MAX) cnt <= '0;
    else                     cnt <= cnt + CNT_W'(1);
  end

  assign tick = (cnt == CNT_MAX);

endmodule

// File: rtl/buzzer_arbiter.sv
// Priority arbiter for the single buzzer: ALARM > key BEEP > MUSIC.
// Every output is registered from the next-state decision.
module buzzer_arbiter
  import buzzer_arbiter_pkg::*;
#(
  parameter int unsigned CLK_PER_MS = 100_000,
  parameter int unsigned BEEP_MS    = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alarm_req,
  input  logic [11:0] alarm_hz,
  input  logic        beep_start,
  input  logic [11:0] beep_hz,
  input  logic        music_req,
  input  logic [11:0] music_hz,
  output logic [11:0] hz_out,
  output logic [1:0]  grant,
  output logic        music_hold,
  output logic        beep_busy
);

  localparam logic [11:0] BEEP_LOAD = 12'(BEEP_MS);

  arb_state_t  state, state_nxt;
  logic        tick;
  logic        start_ok;
  logic        beep_pending, pending_nxt;
  logic [11:0] beep_tone, tone_nxt;
  logic [11:0] beep_timer, timer_nxt;
  logic [11:0] hz_nxt;
  logic        hold_nxt;
  logic        busy_nxt;

  ms_tick_gen #(.CLK_PER_MS(CLK_PER_MS)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // Beep requests are dropped outright while the alarm owns the buzzer.
  assign start_ok = beep_start && !alarm_req && (state != ST_ALARM);

  always_comb begin
    state_nxt   = state;
    pending_nxt = beep_pending;
    tone_nxt    = beep_tone;
    timer_nxt   = beep_timer;

    if (alarm_req) begin
      state_nxt = ST_ALARM;
      timer_nxt = '0;
    end else if (state == ST_BEEP) begin
      if (beep_start) begin
        tone_nxt  = beep_hz;
        timer_nxt = BEEP_LOAD;
      end else if (tick) begin
        if (beep_timer <= 12'd1) begin
          timer_nxt = '0;
          state_nxt = music_req ? ST_MUSIC : ST_IDLE;
        end else begin
          timer_nxt = beep_timer - 12'd1;
        end
      end
    end else begin
      if (start_ok) begin
        pending_nxt = 1'b1;
        tone_nxt    = beep_hz;
      end
      if (start_ok || beep_pending) state_nxt = ST_BEEP;
      else if (music_req)           state_nxt = ST_MUSIC;
      else                          state_nxt = ST_IDLE;
    end

    // Entry into BEEP consumes the pending request and arms the full duration.
    if (state_nxt == ST_BEEP && state != ST_BEEP) begin
      pending_nxt = 1'b0;
      timer_nxt   = BEEP_LOAD;
    end

    case (state_nxt)
      ST_ALARM: hz_nxt = alarm_hz;
      ST_BEEP:  hz_nxt = tone_nxt;
      ST_MUSIC: hz_nxt = music_hz;
      default:  hz_nxt = NO_VOICE;
    endcase

    hold_nxt = music_req && (state_nxt != ST_MUSIC);
    busy_nxt = pending_nxt || (state_nxt == ST_BEEP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      beep_pending <= 1'b0;
      beep_tone    <= NO_VOICE;
      beep_timer   <= '0;
      hz_out       <= NO_VOICE;
      grant        <= GNT_NONE;
      music_hold   <= 1'b0;
      beep_busy    <= 1'b0;
    end else begin
      state        <= state_nxt;
      beep_pending <= pending_nxt;
      beep_tone    <= tone_nxt;
      beep_timer   <= timer_nxt;
      hz_out       <= hz_nxt;
      grant        <= grant_of(state_nxt);
      music_hold   <= hold_nxt;
      beep_busy    <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_buzzer_arbiter.sv
// Self-checking bench for buzzer_arbiter: directed scenarios plus a randomized
// run against a behavioural owner/remaining-ticks model.
module tb_buzzer_arbiter;

  localparam int CLK_PER_MS = 10;
  localparam int BEEP_MS    = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        alarm_req;
  logic [11:0] alarm_hz;
  logic        beep_start;
  logic [11:0] beep_hz;
  logic        music_req;
  logic [11:0] music_hz;
  logic [11:0] hz_out;
  logic [1:0]  grant;
  logic        music_hold;
  logic        beep_busy;

  int n_tests = 0;
  int n_fail  = 0;
  int phase   = 0;   // bench's own view of the ms counter

  buzzer_arbiter #(.CLK_PER_MS(CLK_PER_MS), .BEEP_MS(BEEP_MS)) dut (
    .clk        (clk),
    .rst        (rst),
    .alarm_req  (alarm_req),
    .alarm_hz   (alarm_hz),
    .beep_start (beep_start),
    .beep_hz    (beep_hz),
    .music_req  (music_req),
    .music_hz   (music_hz),
    .hz_out     (hz_out),
    .grant      (grant),
    .music_hold (music_hold),
    .beep_busy  (beep_busy)
  );

  always #5 clk = ~clk;

  // Advance one clock; report whether a ms tick was consumed at this edge.
  task automatic tick_clk(output bit was_tick);
    was_tick = (!rst && phase == CLK_PER_MS - 1);
    @(posedge clk);
    if (rst) phase = 0;
    else     phase = (phase + 1) % CLK_PER_MS;
    #1;
  endtask

  task automatic test_reset();
    bit tk;
    rst = 1'b1; alarm_req = 1'b0; alarm_hz = '0; beep_start = 1'b0;
    beep_hz = '0; music_req = 1'b0; music_hz = '0;
    tick_clk(tk);
    tick_clk(tk);
    n_tests++; if (grant !== 2'd0) begin n_fail++; $display("FAIL reset_grant: got %0d expected 0", grant); end
    n_tests++; if (hz_out !== 12'd0) begin n_fail++; $display("FAIL reset_hz: got %0d expected 0", hz_out); end
    n_tests++; if (music_hold !== 1'b0) begin n_fail++; $display("FAIL reset_hold: got %b expected 0", music_hold); end
    n_tests++; if (beep_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", beep_busy); end
    rst = 1'b0;
  endtask

  task automatic test_music();
    bit tk;
    music_req = 1'b1; music_hz = 12'd440;
    tick_clk(tk);
    n_tests++; if (grant !== 2'd1) begin n_fail++; $display("FAIL music_grant: got %0d expected 1", grant); end
    n_tests++; if (hz_out !== 12'd440) begin n_fail++; $display("FAIL music_hz: got %0d expected 440", hz_out); end
    n_tests++; if (music_hold !== 1'b0) begin n_fail++; $display("FAIL music_hold: got %b expected 0", music_hold); end
  endtask

  task automatic test_beep_over_music();
    bit tk;
    int dur;
    beep_start = 1'b1; beep_hz = 12'd988;
    tick_clk(tk);
    beep_start = 1'b0;
    n_tests++; if (grant !== 2'd2) begin n_fail++; $display("FAIL beep_grant: got %0d expected 2", grant); end
    n_tests++; if (hz_out !== 12'd988) begin n_fail++; $display("FAIL beep_hz: got %0d expected 988", hz_out); end
    n_tests++; if (music_hold !== 1'b1) begin n_fail++; $display("FAIL beep_hold: got %b expected 1", music_hold); end
    n_tests++; if (beep_busy !== 1'b1) begin n_fail++; $display("FAIL beep_busy: got %b expected 1", beep_busy); end
    dur = 1;
    while (grant === 2'd2 && dur < 100) begin
      tick_clk(tk);
      if (grant === 2'd2) dur++;
    end
    n_tests++; if (dur < 21 || dur > 30) begin n_fail++; $display("FAIL beep_duration: got %0d clk expected 21..30", dur); end
    n_tests++; if (grant !== 2'd1) begin n_fail++; $display("FAIL beep_return_grant: got %0d expected 1", grant); end
    n_tests++; if (hz_out !== 12'd440) begin n_fail++; $display("FAIL beep_return_hz: got %0d expected 440", hz_out); end
    n_tests++; if (music_hold !== 1'b0) begin n_fail++; $display("FAIL beep_return_hold: got %b expected 0", music_hold); end
  endtask

  task automatic test_alarm_preempt();
    bit tk;
    beep_start = 1'b1; beep_hz = 12'd988;
    tick_clk(tk);
    beep_start = 1'b0;
    for (int i = 0; i < 12; i++) tick_clk(tk);
    n_tests++; if (grant !== 2'd2) begin n_fail++; $display("FAIL alarm_prebeep_grant: got %0d expected 2", grant); end
    alarm_req = 1'b1; alarm_hz = 12'd880;
    tick_clk(tk);
    n_tests++; if (grant !== 2'd3) begin n_fail++; $display("FAIL alarm_grant: got %0d expected 3", grant); end
    n_tests++; if (hz_out !== 12'd880) begin n_fail++; $display("FAIL alarm_hz: got %0d expected 880", hz_out); end
    n_tests++; if (beep_busy !== 1'b0) begin n_fail++; $display("FAIL alarm_busy: got %b expected 0", beep_busy); end
    n_tests++; if (music_hold !== 1'b1) begin n_fail++; $display("FAIL alarm_hold: got %b expected 1", music_hold); end
    tick_clk(tk);
    alarm_req = 1'b0;
    tick_clk(tk);
    n_tests++; if (grant !== 2'd1) begin n_fail++; $display("FAIL alarm_release_grant: got %0d expected 1", grant); end
    n_tests++; if (hz_out !== 12'd440) begin n_fail++; $display("FAIL alarm_release_hz: got %0d expected 440", hz_out); end
  endtask

  task automatic test_same_cycle();
    bit tk;
    music_req = 1'b0;
    tick_clk(tk);
    beep_start = 1'b1; beep_hz = 12'd523; alarm_req = 1'b1; alarm_hz = 12'd880;
    tick_clk(tk);
    beep_start = 1'b0;
    n_tests++; if (grant !== 2'd3) begin n_fail++; $display("FAIL same_grant: got %0d expected 3", grant); end
    n_tests++; if (beep_busy !== 1'b0) begin n_fail++; $display("FAIL same_busy: got %b expected 0", beep_busy); end
    for (int i = 0; i < 4; i++) tick_clk(tk);
    alarm_req = 1'b0;
    tick_clk(tk);
    n_tests++; if (grant !== 2'd0) begin n_fail++; $display("FAIL same_release_grant: got %0d expected 0", grant); end
    n_tests++; if (hz_out !== 12'd0) begin n_fail++; $display("FAIL same_release_hz: got %0d expected 0", hz_out); end
    for (int i = 0; i < 5; i++) tick_clk(tk);
    n_tests++; if (grant !== 2'd0) begin n_fail++; $display("FAIL same_no_beep: got %0d expected 0", grant); end
  endtask

  task automatic test_retrigger();
    bit tk;
    int ntk;
    int guard;
    beep_start = 1'b1; beep_hz = 12'd988;
    tick_clk(tk);
    beep_start = 1'b0;
    ntk = 0; guard = 0;
    while (ntk < 2 && guard < 40) begin
      tick_clk(tk);
      if (tk) ntk++;
      guard++;
    end
    n_tests++; if (grant !== 2'd2) begin n_fail++; $display("FAIL retrig_mid_grant: got %0d expected 2", grant); end
    beep_start = 1'b1; beep_hz = 12'd262;
    tick_clk(tk);
    beep_start = 1'b0;
    n_tests++; if (hz_out !== 12'd262) begin n_fail++; $display("FAIL retrig_hz: got %0d expected 262", hz_out); end
    n_tests++; if (grant !== 2'd2) begin n_fail++; $display("FAIL retrig_grant: got %0d expected 2", grant); end
    ntk = 0; guard = 0;
    while (grant === 2'd2 && guard < 60) begin
      tick_clk(tk);
      if (tk) ntk++;
      guard++;
    end
    n_tests++; if (ntk !== 3) begin n_fail++; $display("FAIL retrig_ticks: got %0d expected 3", ntk); end
    n_tests++; if (grant !== 2'd0) begin n_fail++; $display("FAIL retrig_end_grant: got %0d expected 0", grant); end
  endtask

  task automatic test_reset_mid_beep();
    bit tk;
    music_req = 1'b0;
    beep_start = 1'b1; beep_hz = 12'd330;
    tick_clk(tk);
    beep_start = 1'b0;
    n_tests++; if (grant !== 2'd2) begin n_fail++; $display("FAIL rstbeep_pre_grant: got %0d expected 2", grant); end
    rst = 1'b1; music_req = 1'b1; music_hz = 12'd440;
    tick_clk(tk);
    n_tests++; if (grant !== 2'd0) begin n_fail++; $display("FAIL rstbeep_grant: got %0d expected 0", grant); end
    n_tests++; if (hz_out !== 12'd0) begin n_fail++; $display("FAIL rstbeep_hz: got %0d expected 0", hz_out); end
    n_tests++; if (music_hold !== 1'b0) begin n_fail++; $display("FAIL rstbeep_hold: got %b expected 0", music_hold); end
    n_tests++; if (beep_busy !== 1'b0) begin n_fail++; $display("FAIL rstbeep_busy: got %b expected 0", beep_busy); end
    rst = 1'b0;
    tick_clk(tk);
    n_tests++; if (grant !== 2'd1) begin n_fail++; $display("FAIL rstbeep_release_grant: got %0d expected 1", grant); end
    n_tests++; if (hz_out !== 12'd440) begin n_fail++; $display("FAIL rstbeep_release_hz: got %0d expected 440", hz_out); end
    n_tests++; if (beep_busy !== 1'b0) begin n_fail++; $display("FAIL rstbeep_release_busy: got %b expected 0", beep_busy); end
  endtask

  // Model: who owns the buzzer, which beep tone, and how many ms ticks remain.
  task automatic test_random();
    bit          tk;
    bit          tick_now;
    int          owner;
    int          left;
    logic [11:0] tone;
    logic [1:0]  e_grant;
    logic [11:0] e_hz;
    logic        e_hold;
    logic        e_busy;
    rst = 1'b1; alarm_req = 1'b0; beep_start = 1'b0; music_req = 1'b0;
    tick_clk(tk);
    rst = 1'b0;
    owner = 0; left = 0; tone = '0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(39) == 0) alarm_req = !alarm_req;
      if ($urandom_range(24) == 0) music_req = !music_req;
      beep_start = ($urandom_range(29) == 0);
      beep_hz = 12'($urandom);
      if ($urandom_range(7) == 0)  music_hz = 12'($urandom);
      if ($urandom_range(15) == 0) alarm_hz = 12'($urandom);
      rst = ($urandom_range(399) == 0);

      tick_now = (!rst && phase == CLK_PER_MS - 1);
      if (rst) begin
        owner = 0; left = 0; tone = '0;
      end else if (alarm_req) begin
        owner = 3; left = 0;
      end else if (owner == 2) begin
        if (beep_start) begin
          tone = beep_hz; left = BEEP_MS;
        end else if (tick_now) begin
          left = left - 1;
          if (left == 0) owner = music_req ? 1 : 0;
        end
      end else if (owner != 3 && beep_start) begin
        owner = 2; tone = beep_hz; left = BEEP_MS;
      end else begin
        owner = music_req ? 1 : 0;
      end

      e_grant = 2'(owner);
      e_hz    = (owner == 3) ? alarm_hz : (owner == 2) ? tone : (owner == 1) ? music_hz : 12'd0;
      e_hold  = !rst && music_req && (owner != 1);
      e_busy  = (owner == 2);

      tick_clk(tk);

      n_tests++; if (grant !== e_grant) begin n_fail++; $display("FAIL rand_grant @%0d: got %0d expected %0d", i, grant, e_grant); end
      n_tests++; if (hz_out !== e_hz) begin n_fail++; $display("FAIL rand_hz @%0d: got %0d expected %0d", i, hz_out, e_hz); end
      n_tests++; if (music_hold !== e_hold) begin n_fail++; $display("FAIL rand_hold @%0d: got %b expected %b", i, music_hold, e_hold); end
      n_tests++; if (beep_busy !== e_busy) begin n_fail++; $display("FAIL rand_busy @%0d: got %b expected %b", i, beep_busy, e_busy); end
    end
    rst = 1'b0; beep_start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; alarm_req = 1'b0; alarm_hz = '0; beep_start = 1'b0;
    beep_hz = '0; music_req = 1'b0; music_hz = '0;
    test_reset();
    test_music();
    test_beep_over_music();
    test_alarm_preempt();
    test_same_cycle();
    test_retrigger();
    test_reset_mid_beep();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
